// File: rtl/pcim_slave_mem.sv
// pcim_slave_mem: AXI4 responder that stands in for host memory on the PCIM interface.
//
// A memory of 2**MEM_AW words, each DATA_W bits wide, sits behind two independent engines.
// Each engine handles one burst at a time.
// - Write engine: accepts AW, then the W beats, then returns B.
// - Read engine: accepts AR, then returns the R beats.
// Only INCR bursts are supported. The word index is ((addr - BASE_ADDR) >> log2(DATA_W/8))
// modulo the depth, and each beat advances the index by one word.
//
// Optional build macro PCIM_SLAVE_RANGE_CHECK_EN:
// - Every beat address is checked against [BASE_ADDR, BASE_ADDR + memory size).
// - A write beat outside that range is dropped, and the burst reports DECERR.
// - A read beat outside that range returns zero data with DECERR.
// When the macro is undefined, upper address bits alias onto the memory.
//
// Ports:
//   clk_main_a0, rst_main        clock, synchronous active-high reset
//   pcim_aw*                     write address channel (id, addr, len, size, valid/ready)
//   pcim_w*                      write data channel (wid ignored)
//   pcim_b*                      write response channel
//   pcim_ar*                     read address channel
//   pcim_r*                      read data channel
module pcim_slave_mem #(
  parameter int unsigned       DATA_W    = 512,
  parameter int unsigned       ADDR_W    = 64,
  parameter int unsigned       ID_W      = 16,
  parameter int unsigned       MEM_AW    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk_main_a0,
  input  logic                rst_main,
  input  logic [ID_W-1:0]     pcim_awid,
  input  logic [ADDR_W-1:0]   pcim_awaddr,
  input  logic [7:0]          pcim_awlen,
  input  logic [2:0]          pcim_awsize,
  input  logic                pcim_awvalid,
  output logic                pcim_awready,
  input  logic [ID_W-1:0]     pcim_wid,
  input  logic [DATA_W-1:0]   pcim_wdata,
  input  logic [DATA_W/8-1:0] pcim_wstrb,
  input  logic                pcim_wlast,
  input  logic                pcim_wvalid,
  output logic                pcim_wready,
  output logic [ID_W-1:0]     pcim_bid,
  output logic [1:0]          pcim_bresp,
  output logic                pcim_bvalid,
  input  logic                pcim_bready,
  input  logic [ID_W-1:0]     pcim_arid,
  input  logic [ADDR_W-1:0]   pcim_araddr,
  input  logic [7:0]          pcim_arlen,
  input  logic [2:0]          pcim_arsize,
  input  logic                pcim_arvalid,
  output logic                pcim_arready,
  output logic [ID_W-1:0]     pcim_rid,
  output logic [DATA_W-1:0]   pcim_rdata,
  output logic [1:0]          pcim_rresp,
  output logic                pcim_rlast,
  output logic                pcim_rvalid,
  input  logic                pcim_rready
);

  localparam int unsigned       STRB_W     = DATA_W / 8;
  localparam int unsigned       OFF_B      = $clog2(STRB_W);
  localparam int unsigned       DEPTH      = 2 ** MEM_AW;
  localparam logic [2:0]        FULL_SIZE  = 3'(OFF_B);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(STRB_W);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RBurst} r_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write engine state
  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   bid_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] w_off_q;
  logic [7:0]        w_len_q, w_cnt_q;
  logic              w_slverr_q, w_decerr_q, w_slverr_d, w_decerr_d;
  logic              aw_hs, w_hs, w_last_beat, w_in_range;

  // Read engine state
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;
  logic [ADDR_W-1:0] r_off_q, r_off_next;
  logic [7:0]        r_len_q, r_cnt_q;
  logic              r_slverr_q, r_slverr_next, r_last_next;
  logic              ar_hs, r_hs, r_load, r_in_range;

  logic unused_wid;
  assign unused_wid = ^pcim_wid;

`ifdef PCIM_SLAVE_RANGE_CHECK_EN
  localparam logic [ADDR_W-1:0] MEM_BYTES = BEAT_BYTES << MEM_AW;
  // An address below BASE_ADDR underflows to a huge offset, so it also fails this test.
  assign w_in_range = (w_off_q < MEM_BYTES);
  assign r_in_range = (r_off_next < MEM_BYTES);
`else
  logic unused_off;
  assign unused_off = ^{w_off_q, r_off_q};
  assign w_in_range = 1'b1;
  assign r_in_range = 1'b1;
`endif

  // ---------------------------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------------------------
  assign aw_hs       = pcim_awvalid && pcim_awready;
  assign w_hs        = pcim_wvalid && pcim_wready;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_slverr_d  = w_slverr_q | (pcim_wlast != w_last_beat);
  assign w_decerr_d  = w_decerr_q | !w_in_range;

  always_comb begin
    w_state_d    = w_state_q;
    pcim_awready = 1'b0;
    pcim_wready  = 1'b0;
    pcim_bvalid  = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        pcim_awready = 1'b1;
        if (pcim_awvalid) w_state_d = WData;
      end
      WData: begin
        pcim_wready = 1'b1;
        if (pcim_wvalid && w_last_beat) w_state_d = WResp;
      end
      WResp: begin
        pcim_bvalid = 1'b1;
        if (pcim_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
    // Handshake outputs stay low for the whole time reset is asserted.
    if (rst_main) begin
      pcim_awready = 1'b0;
      pcim_wready  = 1'b0;
      pcim_bvalid  = 1'b0;
    end
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      w_state_q  <= WIdle;
      bid_q      <= '0;
      bresp_q    <= 2'b00;
      w_off_q    <= '0;
      w_len_q    <= 8'd0;
      w_cnt_q    <= 8'd0;
      w_slverr_q <= 1'b0;
      w_decerr_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        bid_q      <= pcim_awid;
        w_off_q    <= pcim_awaddr - BASE_ADDR;
        w_len_q    <= pcim_awlen;
        w_cnt_q    <= 8'd0;
        w_slverr_q <= (pcim_awsize != FULL_SIZE);
        w_decerr_q <= 1'b0;
      end
      if (w_hs) begin
        w_off_q    <= w_off_q + BEAT_BYTES;
        w_cnt_q    <= w_cnt_q + 8'd1;
        w_slverr_q <= w_slverr_d;
        w_decerr_q <= w_decerr_d;
        if (w_last_beat) begin
          bresp_q <= w_decerr_d ? 2'b11 : (w_slverr_d ? 2'b10 : 2'b00);
        end
      end
    end
  end

  // The memory is never cleared. A write to the word being read lands after the read sample.
  always_ff @(posedge clk_main_a0) begin
    if (w_hs && w_in_range) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (pcim_wstrb[b]) mem[w_off_q[OFF_B +: MEM_AW]][b*8 +: 8] <= pcim_wdata[b*8 +: 8];
      end
    end
  end

  assign pcim_bid   = bid_q;
  assign pcim_bresp = bresp_q;

  // ---------------------------------------------------------------------------------------------
  // Read engine: the next beat is loaded into rdata_q when AR is accepted and on each accepted
  // beat that is not the last one.
  // ---------------------------------------------------------------------------------------------
  assign ar_hs         = pcim_arvalid && pcim_arready;
  assign r_hs          = pcim_rvalid && pcim_rready;
  assign r_load        = ar_hs || (r_hs && !rlast_q);
  assign r_off_next    = ar_hs ? (pcim_araddr - BASE_ADDR) : (r_off_q + BEAT_BYTES);
  assign r_slverr_next = ar_hs ? (pcim_arsize != FULL_SIZE) : r_slverr_q;
  assign r_last_next   = ar_hs ? (pcim_arlen == 8'd0) : ((r_cnt_q + 8'd1) == r_len_q);

  always_comb begin
    r_state_d    = r_state_q;
    pcim_arready = 1'b0;
    pcim_rvalid  = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        pcim_arready = 1'b1;
        if (pcim_arvalid) r_state_d = RBurst;
      end
      RBurst: begin
        pcim_rvalid = 1'b1;
        if (pcim_rready && rlast_q) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
    if (rst_main) begin
      pcim_arready = 1'b0;
      pcim_rvalid  = 1'b0;
    end
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      r_state_q  <= RIdle;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      rlast_q    <= 1'b0;
      r_off_q    <= '0;
      r_len_q    <= 8'd0;
      r_cnt_q    <= 8'd0;
      r_slverr_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rid_q   <= pcim_arid;
        r_len_q <= pcim_arlen;
      end
      if (r_load) begin
        r_off_q    <= r_off_next;
        r_cnt_q    <= ar_hs ? 8'd0 : (r_cnt_q + 8'd1);
        r_slverr_q <= r_slverr_next;
        rlast_q    <= r_last_next;
        rdata_q    <= r_in_range ? mem[r_off_next[OFF_B +: MEM_AW]] : '0;
        rresp_q    <= !r_in_range ? 2'b11 : (r_slverr_next ? 2'b10 : 2'b00);
      end
    end
  end

  assign pcim_rid   = rid_q;
  assign pcim_rdata = rdata_q;
  assign pcim_rresp = rresp_q;
  assign pcim_rlast = rlast_q;

endmodule

// File: tb/tb_pcim_slave_mem.sv
module tb_pcim_slave_mem;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SPAN  = 64'h0000_0000_0001_0000;
  localparam int          DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst_main = 1'b1;
  logic [15:0]  pcim_awid, pcim_wid, pcim_bid, pcim_arid, pcim_rid;
  logic [63:0]  pcim_awaddr, pcim_araddr, pcim_wstrb;
  logic [7:0]   pcim_awlen, pcim_arlen;
  logic [2:0]   pcim_awsize, pcim_arsize;
  logic         pcim_awvalid, pcim_awready, pcim_wlast, pcim_wvalid, pcim_wready;
  logic [1:0]   pcim_bresp, pcim_rresp;
  logic         pcim_bvalid, pcim_bready, pcim_arvalid, pcim_arready;
  logic [511:0] pcim_wdata, pcim_rdata;
  logic         pcim_rlast, pcim_rvalid, pcim_rready;

  always #5 clk = ~clk;

  pcim_slave_mem #(
    .DATA_W(512), .ADDR_W(64), .ID_W(16), .MEM_AW(10), .BASE_ADDR(BASE)
  ) dut (
    .clk_main_a0(clk), .rst_main(rst_main),
    .pcim_awid(pcim_awid), .pcim_awaddr(pcim_awaddr), .pcim_awlen(pcim_awlen),
    .pcim_awsize(pcim_awsize), .pcim_awvalid(pcim_awvalid), .pcim_awready(pcim_awready),
    .pcim_wid(pcim_wid), .pcim_wdata(pcim_wdata), .pcim_wstrb(pcim_wstrb),
    .pcim_wlast(pcim_wlast), .pcim_wvalid(pcim_wvalid), .pcim_wready(pcim_wready),
    .pcim_bid(pcim_bid), .pcim_bresp(pcim_bresp), .pcim_bvalid(pcim_bvalid),
    .pcim_bready(pcim_bready),
    .pcim_arid(pcim_arid), .pcim_araddr(pcim_araddr), .pcim_arlen(pcim_arlen),
    .pcim_arsize(pcim_arsize), .pcim_arvalid(pcim_arvalid), .pcim_arready(pcim_arready),
    .pcim_rid(pcim_rid), .pcim_rdata(pcim_rdata), .pcim_rresp(pcim_rresp),
    .pcim_rlast(pcim_rlast), .pcim_rvalid(pcim_rvalid), .pcim_rready(pcim_rready)
  );

  typedef struct {
    logic [15:0] id;
    logic [1:0]  resp;
  } bexp_t;
  typedef struct {
    logic [15:0]  id;
    logic [511:0] data;
    logic [1:0]   resp;
    logic         last;
  } rexp_t;

  bexp_t        bq[$];
  rexp_t        rq[$];
  logic [511:0] mdl [DEPTH];
  logic [511:0] wq_data[$];
  logic [63:0]  wq_strb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           rmode = 0;
  int           bmode = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference addressing: word = ((addr - BASE) / 64 + beat) mod depth.
  function automatic int widx(input logic [63:0] addr, input int beat);
    logic [63:0] w;
    w = ((addr - BASE) / 64 + 64'(beat)) % 64'(DEPTH);
    return int'(w);
  endfunction

  function automatic bit inr(input logic [63:0] addr, input int beat);
    bit in;
    in = ((addr - BASE) + 64'(beat) * 64) < SPAN;
`ifndef PCIM_SLAVE_RANGE_CHECK_EN
    in = 1'b1;
`endif
    return in;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic fill(input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      wq_data.push_back(rand512());
      wq_strb.push_back(full ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom});
    end
  endtask

  // Waits for a ready seen at negedge followed by the handshake edge; returns cycles waited.
  task automatic hs_wait(input int which, input string name, output int cyc);
    bit ok;
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      case (which)
        0: ok = pcim_awready;
        1: ok = pcim_wready;
        default: ok = pcim_arready;
      endcase
      @(posedge clk);
      cyc++;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: no handshake in %0d cycles, required one", name, cyc);
    end
  endtask

  task automatic drain(input bit is_read);
    int i;
    int left;
    i = 0;
    left = is_read ? rq.size() : bq.size();
    while (left != 0 && i < 3000) begin
      @(posedge clk);
      i++;
      left = is_read ? rq.size() : bq.size();
    end
    check(is_read ? "r_burst_complete" : "b_response_seen", left, 0);
    if (is_read) rq.delete();
    else bq.delete();
  endtask

  task automatic write_burst(input logic [15:0] id, input logic [63:0] addr, input int len,
                             input logic [2:0] size, input int bad, input int nbeats);
    int           cyc;
    bit           dec;
    logic [511:0] d;
    logic [63:0]  s;
    bexp_t        e;
    dec = 1'b0;
    @(posedge clk);
    #1;
    pcim_awid = id; pcim_awaddr = addr; pcim_awlen = 8'(len); pcim_awsize = size;
    pcim_awvalid = 1'b1;
    hs_wait(0, "aw_handshake", cyc);
    #1;
    pcim_awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d = wq_data.pop_front();
      s = wq_strb.pop_front();
      pcim_wdata = d; pcim_wstrb = s; pcim_wid = 16'($urandom);
      pcim_wlast = (b == len) ^ (b == bad);
      pcim_wvalid = 1'b1;
      hs_wait(1, "w_handshake", cyc);
      if (b == 0) check("w_first_beat_latency", cyc, 1);
      if (inr(addr, b)) begin
        for (int k = 0; k < 64; k++) if (s[k]) mdl[widx(addr, b)][k*8 +: 8] = d[k*8 +: 8];
      end else begin
        dec = 1'b1;
      end
      #1;
    end
    pcim_wvalid = 1'b0;
    pcim_wlast = 1'b0;
    if (nbeats == len + 1) begin
      e.id = id;
      e.resp = dec ? 2'b11 : ((size != 3'd6 || bad >= 0) ? 2'b10 : 2'b00);
      bq.push_back(e);
      drain(1'b0);
    end
  endtask

  task automatic read_burst(input logic [15:0] id, input logic [63:0] addr, input int len,
                            input logic [2:0] size);
    int    cyc;
    rexp_t e;
    for (int b = 0; b <= len; b++) begin
      e.id = id;
      e.last = (b == len);
      if (inr(addr, b)) begin
        e.data = mdl[widx(addr, b)];
        e.resp = (size != 3'd6) ? 2'b10 : 2'b00;
      end else begin
        e.data = '0;
        e.resp = 2'b11;
      end
      rq.push_back(e);
    end
    @(posedge clk);
    #1;
    pcim_arid = id; pcim_araddr = addr; pcim_arlen = 8'(len); pcim_arsize = size;
    pcim_arvalid = 1'b1;
    hs_wait(2, "ar_handshake", cyc);
    #1;
    pcim_arvalid = 1'b0;
    @(negedge clk);
    check("r_first_beat_latency", pcim_rvalid, 1'b1);
    drain(1'b1);
  endtask

  // Ready drivers
  initial begin
    pcim_rready = 1'b1;
    pcim_bready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: pcim_rready = 1'b1;
        1: pcim_rready = !pcim_rready;
        default: pcim_rready = 1'($urandom_range(0, 1));
      endcase
      pcim_bready = (bmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // R monitor
  bit           r_stalled = 1'b0;
  logic [511:0] r_held;
  rexp_t        r_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_main) begin
        r_stalled = 1'b0;
        continue;
      end
      if (r_stalled) begin
        check("r_stall_valid_held", pcim_rvalid, 1'b1);
        check("r_stall_data_held", pcim_rdata, r_held);
      end
      r_stalled = pcim_rvalid && !pcim_rready;
      r_held = pcim_rdata;
      if (pcim_rvalid && pcim_rready) begin
        if (rq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL r_unexpected_beat: got id %0h, required no beat", pcim_rid);
        end else begin
          r_e = rq.pop_front();
          check("r_id", pcim_rid, r_e.id);
          check("r_data", pcim_rdata, r_e.data);
          check("r_resp", pcim_rresp, r_e.resp);
          check("r_last", pcim_rlast, r_e.last);
        end
      end
    end
  end

  // B monitor
  bit          b_stalled = 1'b0;
  logic [15:0] b_held;
  bexp_t       b_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_main) begin
        b_stalled = 1'b0;
        continue;
      end
      if (b_stalled) begin
        check("b_stall_valid_held", pcim_bvalid, 1'b1);
        check("b_stall_id_held", pcim_bid, b_held);
      end
      b_stalled = pcim_bvalid && !pcim_bready;
      b_held = pcim_bid;
      if (pcim_bvalid && pcim_bready) begin
        if (bq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected: got id %0h, required no response", pcim_bid);
        end else begin
          b_e = bq.pop_front();
          check("b_id", pcim_bid, b_e.id);
          check("b_resp", pcim_bresp, b_e.resp);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  int          len;
  int          bad;
  logic [63:0] a;
  logic [2:0]  sz;

  initial begin
    pcim_awid = '0; pcim_awaddr = '0; pcim_awlen = '0; pcim_awsize = '0; pcim_awvalid = 1'b0;
    pcim_wid = '0; pcim_wdata = '0; pcim_wstrb = '0; pcim_wlast = 1'b0; pcim_wvalid = 1'b0;
    pcim_arid = '0; pcim_araddr = '0; pcim_arlen = '0; pcim_arsize = '0; pcim_arvalid = 1'b0;
    rst_main = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", pcim_awready, 1'b0);
    check("rst_wready", pcim_wready, 1'b0);
    check("rst_bvalid", pcim_bvalid, 1'b0);
    check("rst_arready", pcim_arready, 1'b0);
    check("rst_rvalid", pcim_rvalid, 1'b0);
    check("rst_bid", pcim_bid, 0);
    check("rst_bresp", pcim_bresp, 0);
    check("rst_rid", pcim_rid, 0);
    check("rst_rresp", pcim_rresp, 0);
    check("rst_rdata", pcim_rdata, 0);
    check("rst_rlast", pcim_rlast, 1'b0);
    @(posedge clk);
    #1;
    rst_main = 1'b0;
    @(negedge clk);
    check("idle_awready", pcim_awready, 1'b1);
    check("idle_arready", pcim_arready, 1'b1);

    // Give every word a known value.
    for (int k = 0; k < 4; k++) begin
      fill(256, 1'b1);
      write_burst(16'(k), BASE + 64'(k) * 64'd16384, 255, 3'd6, -1, 256);
    end

    // Four-beat write of 1..4 at offset 0x40, then read it back.
    for (int i = 1; i <= 4; i++) begin
      wq_data.push_back(512'(i));
      wq_strb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    end
    write_burst(16'h5, BASE + 64'h40, 3, 3'd6, -1, 4);
    read_burst(16'h7, BASE + 64'h40, 3, 3'd6);

    // Partial strobe over an all-ones word.
    wq_data.push_back({512{1'b1}});
    wq_strb.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    write_burst(16'h11, BASE + 64'd20 * 64, 0, 3'd6, -1, 1);
    wq_data.push_back('0);
    wq_strb.push_back(64'h0000_0000_0000_00FF);
    write_burst(16'h12, BASE + 64'd20 * 64, 0, 3'd6, -1, 1);
    read_burst(16'h13, BASE + 64'd20 * 64, 0, 3'd6);

    // Wrap from the last word with rready toggling every cycle.
    rmode = 1;
    read_burst(16'h3, BASE + 64'd1023 * 64, 7, 3'd6);
    rmode = 0;

    // Early wlast on beat 0: SLVERR, both beats still written.
    fill(2, 1'b1);
    write_burst(16'h4, BASE + 64'h800, 1, 3'd6, 0, 2);
    read_burst(16'h14, BASE + 64'h800, 1, 3'd6);

    // Same-cycle AW/AR to one word: the read sees the old contents, a later read sees the new.
    fill(1, 1'b1);
    fork
      write_burst(16'h6, BASE + 64'd30 * 64, 0, 3'd6, -1, 1);
      read_burst(16'h8, BASE + 64'd30 * 64, 0, 3'd6);
    join
    read_burst(16'h9, BASE + 64'd30 * 64, 0, 3'd6);

    // One word past the end of memory.
    read_burst(16'hA, BASE + SPAN, 0, 3'd6);

    // Reset in the middle of a write burst: no B, the two accepted beats persist.
    fill(4, 1'b1);
    write_burst(16'h10, BASE + 64'd128 * 64, 3, 3'd6, -1, 2);
    wq_data.delete();
    wq_strb.delete();
    rst_main = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_main = 1'b0;
    @(negedge clk);
    check("mid_rst_bvalid", pcim_bvalid, 1'b0);
    check("mid_rst_wready", pcim_wready, 1'b0);
    check("mid_rst_awready", pcim_awready, 1'b1);
    repeat (5) @(posedge clk);
    read_burst(16'h15, BASE + 64'd128 * 64, 3, 3'd6);

    // Randomized traffic.
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(0, 15);
      a = BASE + 64'($urandom_range(0, 2047)) * 64;
      sz = ($urandom_range(0, 4) == 0) ? 3'd5 : 3'd6;
      bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      rmode = $urandom_range(0, 2);
      bmode = $urandom_range(0, 1);
      fill(len + 1, 1'($urandom_range(0, 1)));
      write_burst(16'($urandom), a, len, sz, bad, len + 1);
      read_burst(16'($urandom), a, len, ($urandom_range(0, 4) == 0) ? 3'd5 : 3'd6);
      read_burst(16'($urandom), BASE + 64'($urandom_range(0, 2047)) * 64, $urandom_range(0, 15),
                 3'd6);
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcim_slave_mem.md
Name: pcim_slave_mem

Overview:
- AXI4 responder for the PCIM master interface.
- Stands in for host memory so CL DMA/portal logic can be exercised end-to-end in simulation and on-chip loopback builds without the shell.
- Backed by a word-addressed memory array.
- Independent write and read engines; one outstanding burst per direction.

Parameters:
- DATA_W, 512, data width in bits; strobe width is DATA_W/8.
- ADDR_W, 64, address width.
- ID_W, 16, transaction ID width.
- MEM_AW, 10, log2 of memory depth in DATA_W words (default 64 KiB).
- BASE_ADDR, 64'h0, byte address mapped to memory word 0.

Ports:
- clk_main_a0  in  1  sole clock
- rst_main  in  1  synchronous, active-high reset
- pcim_awid  in  ID_W  write ID
- pcim_awaddr  in  ADDR_W  write byte address
- pcim_awlen  in  8  beats-1
- pcim_awsize  in  3  beat size
- pcim_awvalid  in  1
- pcim_awready  out  1
- pcim_wid  in  ID_W  ignored
- pcim_wdata  in  DATA_W
- pcim_wstrb  in  DATA_W/8
- pcim_wlast  in  1
- pcim_wvalid  in  1
- pcim_wready  out  1
- pcim_bid  out  ID_W
- pcim_bresp  out  2
- pcim_bvalid  out  1
- pcim_bready  in  1
- pcim_arid  in  ID_W
- pcim_araddr  in  ADDR_W
- pcim_arlen  in  8
- pcim_arsize  in  3
- pcim_arvalid  in  1
- pcim_arready  out  1
- pcim_rid  out  ID_W
- pcim_rdata  out  DATA_W
- pcim_rresp  out  2
- pcim_rlast  out  1
- pcim_rvalid  out  1
- pcim_rready  in  1

Behaviour:
- Reset: all valid/ready outputs 0; bid/rid/bresp/rresp/rdata/rlast 0; both FSMs to IDLE; memory contents not cleared.
- Word index = ((addr - BASE_ADDR) >> log2(DATA_W/8)) mod 2^MEM_AW. Beats advance index +1 and wrap modulo depth. Burst type INCR only; no burst input.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - awready=1 only in W_IDLE. AW handshake at cycle N latches id, index, len; beat counter = 0; wready=1 from cycle N+1.
  - Each W handshake writes the bytes enabled by wstrb only.
  - Final beat is counter==awlen; it occurs at cycle M and bvalid=1 at M+1.
  - bvalid held with bid stable until bready; awready returns the cycle after the B handshake.
  - bresp=2'b10 (SLVERR) if awsize!=log2(DATA_W/8), or wlast!=(counter==awlen) on any beat; otherwise 2'b00. Data is written regardless.
- Read FSM R_IDLE -> R_BURST -> R_IDLE:
  - arready=1 only in R_IDLE. AR handshake at cycle N gives the first rvalid at N+1.
  - rdata registered from mem[index] and held stable while rvalid && !rready. One beat per cycle under continuous rready.
  - rlast=1 on beat arlen. The handshake of that beat returns the FSM to R_IDLE; arready is 1 the next cycle.
  - rresp=2'b10 on every beat if arsize is not full width, else 2'b00.
- Same-word write and read in the same cycle: read returns pre-write data (read-first).
- AW and AR engines are fully independent; simultaneous handshakes are both accepted.
- rst_main mid-burst: burst is abandoned, no B/R completion is issued, FSMs go to IDLE; memory writes already performed persist.

Optional Feature:
- PCIM_SLAVE_RANGE_CHECK_EN defined:
  - In range means BASE_ADDR <= addr < BASE_ADDR + 2^MEM_AW*(DATA_W/8); each beat address is checked.
  - Out-of-range write beats are dropped; bresp=2'b11 (DECERR) overrides SLVERR.
  - Out-of-range read beats return rdata=0 with rresp=2'b11.
- Undefined: no range check; upper address bits alias via the modulo rule, and DECERR is never produced.

Test Plan:
- Write awaddr=0x40, awlen=3, size 6, all-ones wstrb, data 0x1..0x4, then read the same range -> bresp=00, bid echoes awid=0x5; rdata 0x1..0x4, rlast only on the 4th beat, rresp=00.
- Write with wstrb=64'h0000_0000_0000_00FF over preloaded word 0xFF..FF with data 0 -> readback has low 8 bytes 0, rest 0xFF.
- Read awlen=7 starting at the last word (index 1023) with rready toggling 1,0,1,0 -> beats return words 1023,0,1..6; rdata stable during stalls.
- Write awlen=1 with wlast asserted on beat 0 -> bresp=2'b10; both beats are written.
- AW and AR handshaked in the same cycle to the same word -> read returns old data, write completes; in the next read the new data is visible.
- Range check enabled, araddr=BASE_ADDR+0x10000 with arlen=0 -> rresp=2'b11, rdata=0. Macro undefined, same stimulus -> word 0 returned with rresp=00.
